ppa_share_arbiter: RTL

Round-robin arbiter and sequencer that time-shares one combinational 16-bit PPA (Brent-Kung) adder among several FIR datapath requesters. Each request carries 32-bit operands. A request is either a narrow 16-bit add (one adder pass) or a wide 32-bit add (two passes, with the carry chained from the low half to the high half). Results return on a single valid/ready response channel tagged with the requester ID.

---
 rtl/ppa_arb_pkg.sv | 18 +
 rtl/PPA.sv | 60 ++++++
 rtl/ppa_share_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ppa_arb_pkg.sv
// ppa_arb_pkg
//   Shared definitions for the PPA share arbiter: sequencer state encoding
//   and default sizing constants.
package ppa_arb_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_N_REQ = 4;

  // Sequencer states: IDLE arbitrates, LO/HI are the two adder passes,
  // RESP holds the result until downstream takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/PPA.sv
// PPA
//   Combinational WIDTH-bit Brent-Kung parallel-prefix adder.
//   Ports:
//     add_1, add_2 : operands
//     c_in         : carry-in
//     sum          : add_1 + add_2 + c_in (mod 2^WIDTH)
//     c_out        : carry-out of the top bit
//   WIDTH must be a power of two.
module PPA #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] add_1,
  input  logic [WIDTH-1:0] add_2,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int LVL = $clog2(WIDTH);

  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_pre;
  logic [WIDTH-1:0] p_pre;
  logic [WIDTH-1:0] carry;

  always_comb begin
    g_bit = add_1 & add_2;
    p_bit = add_1 ^ add_2;
    g_pre = g_bit;
    p_pre = p_bit;
    // Fold the carry-in into bit 0 so the prefix tree yields true carries.
    g_pre[0] = g_bit[0] | (p_bit[0] & c_in);

    // Up-sweep: build group (G,P) at indices 2^(l+1)-1 mod 2^(l+1).
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((((i + 1) % (1 << (l + 1))) == 0) && (i >= (1 << l))) begin
          g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i - (1 << l)]);
          p_pre[i] = p_pre[i] & p_pre[i - (1 << l)];
        end
      end
    end

    // Down-sweep: fill in the remaining prefixes from the completed ones.
    for (int l = LVL - 2; l >= 0; l--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && (i >= (1 << (l + 1)))) begin
          g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i - (1 << l)]);
          p_pre[i] = p_pre[i] & p_pre[i - (1 << l)];
        end
      end
    end

    carry    = {g_pre[WIDTH-2:0], c_in};
    sum      = p_bit ^ carry;
    c_out    = g_pre[WIDTH-1];
  end

endmodule

// File: rtl/ppa_share_arbiter.sv
// ppa_share_arbiter
//   Round-robin arbiter/sequencer time-sharing one WIDTH-bit PPA adder among
//   N_REQ requesters. Narrow adds take one adder pass, wide (2*WIDTH) adds
//   take two passes with the carry chained low -> high.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     req_valid/req_ready : per-requester handshake (ready is one-hot or 0)
//     req_a, req_b        : flattened 2*WIDTH operands, requester i at [i*2W +: 2W]
//     req_cin, req_wide   : per-requester carry-in and wide-add select
//     resp_valid/ready    : response handshake
//     resp_id             : requester index of the result
//     resp_sum, resp_cout : result and final-pass carry-out
module ppa_share_arbiter
  import ppa_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*2*WIDTH-1:0]   req_a,
  input  logic [N_REQ*2*WIDTH-1:0]   req_b,
  input  logic [N_REQ-1:0]           req_cin,
  input  logic [N_REQ-1:0]           req_wide,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(N_REQ)-1:0]   resp_id,
  output logic [2*WIDTH-1:0]         resp_sum,
  output logic                       resp_cout
);

  localparam int IDW = $clog2(N_REQ);
  localparam int DW  = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q;
  logic [DW-1:0]      a_q, b_q;
  logic               cin_q, wide_q;
  logic [IDW-1:0]     id_q;
  logic [WIDTH-1:0]   sum_lo_q, sum_hi_q;
  logic               carry_q;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     rr_ptr_next;
  logic               accept;
  logic [DW-1:0]      sel_a, sel_b;
  logic               sel_cin, sel_wide;

  logic [WIDTH-1:0]   add_a, add_b, add_sum;
  logic               add_cin, add_cout;
  logic [WIDTH-1:0]   hi_half;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  assign sel_a    = req_a[int'(grant_idx) * DW +: DW];
  assign sel_b    = req_b[int'(grant_idx) * DW +: DW];
  assign sel_cin  = req_cin[grant_idx];
  assign sel_wide = req_wide[grant_idx];

  // Reset wins over any pending request in the same cycle.
  assign accept      = (state_q == IDLE) && grant_found && !rst;
  assign req_ready   = accept ? (N_REQ'(1) << grant_idx) : '0;
  assign rr_ptr_next = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = LO;
      LO:   state_d = wide_q ? HI : RESP;
      HI:   state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Adder operands are parked at zero outside the two compute passes.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      LO: begin
        add_a   = a_q[WIDTH-1:0];
        add_b   = b_q[WIDTH-1:0];
        add_cin = cin_q;
      end
      HI: begin
        add_a   = a_q[DW-1:WIDTH];
        add_b   = b_q[DW-1:WIDTH];
        add_cin = carry_q;
      end
      default: ;
    endcase
  end

  PPA #(.WIDTH(WIDTH)) u_ppa (
    .add_1 (add_a),
    .add_2 (add_b),
    .c_in  (add_cin),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      wide_q   <= 1'b0;
      id_q     <= '0;
      sum_lo_q <= '0;
      sum_hi_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q      <= sel_a;
        b_q      <= sel_b;
        cin_q    <= sel_cin;
        wide_q   <= sel_wide;
        id_q     <= grant_idx;
        rr_ptr_q <= rr_ptr_next;
      end
      if (state_q == LO) begin
        sum_lo_q <= add_sum;
        carry_q  <= add_cout;
      end
      if (state_q == HI) begin
        sum_hi_q <= add_sum;
        carry_q  <= add_cout;
      end
    end
  end

  // A narrow result reports zero in the upper half regardless of stale sum_hi.
  assign hi_half    = wide_q ? sum_hi_q : {WIDTH{1'b0}};
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_sum   = {hi_half, sum_lo_q};
  assign resp_cout  = carry_q;

endmodule
